// File: rtl/cdb_request_buffer.sv
// ---------------------------------------------------------------------------
// rv32i_types / cdb_request_buffer
//
// Per-FU completion buffer sitting between a functional unit and the common
// data bus arbiter. Results from the FU are queued in a small circular FIFO.
// The head entry is presented to the arbiter as a CDB request until granted.
// A wait counter tracks how long the current head has been starved, so the
// arbiter can apply age-based priority.
//
// Parameters
//   DEPTH       result entries held (power of two, >= 2)
//   WAIT_W      width of the head-wait counter
//   SIM_CHECKS  enable simulation-time protocol checks ($error)
//
// Ports
//   clk              clock, rising edge
//   rst              synchronous active-high reset
//   fu_result        completed result from the owning FU
//   fu_result_valid  fu_result valid this cycle
//   fu_ready         buffer can take a result this cycle (not full)
//   flush            discard every buffered result
//   complete         head entry to the CDB arbiter ('0 when empty)
//   complete_valid   CDB request: head entry valid
//   cdb_grant        grant from the CDB arbiter for this FU
//   count            occupied entries
//   head_wait        cycles the current head has waited ungranted (saturating)
// ---------------------------------------------------------------------------

package rv32i_types;
  // Result broadcast on the CDB: ROB/physical tag plus the produced value.
  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] data;
  } cdb_entry_t;
endpackage

module cdb_request_buffer
  import rv32i_types::*;
#(
  parameter int DEPTH      = 4,
  parameter int WAIT_W     = 8,
  parameter bit SIM_CHECKS = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  cdb_entry_t               fu_result,
  input  logic                     fu_result_valid,
  output logic                     fu_ready,
  input  logic                     flush,
  output cdb_entry_t               complete,
  output logic                     complete_valid,
  input  logic                     cdb_grant,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WAIT_W-1:0]        head_wait
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  cdb_entry_t          mem [DEPTH];
  logic [PW-1:0]       rd_ptr, wr_ptr;
  logic [CW-1:0]       count_nxt;
  logic [WAIT_W-1:0]   head_wait_nxt;
  logic                push, pop;

  // fu_ready is a function of occupancy only. Letting a same-cycle grant open
  // a slot when full would make fu_ready depend on the arbiter, creating a
  // combinational path across FUs; a full buffer simply drops the result.
  assign fu_ready       = (count != CW'(DEPTH));
  assign complete_valid = (count != '0);

  // Storage is not reset, so mask the head whenever no slot is valid.
  assign complete = complete_valid ? mem[rd_ptr] : '0;

  assign push = fu_result_valid && fu_ready && !flush;
  assign pop  = cdb_grant && complete_valid && !flush;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // A new head (after a pop) or an emptied buffer restarts the wait count.
  // A push into an empty buffer leaves it at 0: the entry only becomes the
  // head on the following cycle, and that is when waiting starts.
  always_comb begin
    head_wait_nxt = head_wait;
    if (flush || pop || count_nxt == '0)
      head_wait_nxt = '0;
    else if (complete_valid && !cdb_grant && head_wait != '1)
      head_wait_nxt = head_wait + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      head_wait <= '0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      head_wait <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_nxt;
      head_wait <= head_wait_nxt;
    end
  end

  // Data path only; validity is carried by count, so no reset needed here.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= fu_result;
  end

  always_ff @(posedge clk) begin
    if (SIM_CHECKS && !rst) begin
      if (fu_result_valid && !fu_ready && !flush)
        $error("cdb_request_buffer: result dropped, buffer full (tag %0d)", fu_result.tag);
      if (count > CW'(DEPTH))
        $error("cdb_request_buffer: count %0d exceeds DEPTH %0d", count, DEPTH);
      if (pop && count == '0)
        $error("cdb_request_buffer: pop while empty");
    end
  end

endmodule

// File: tb/tb_cdb_request_buffer.sv
// ---------------------------------------------------------------------------
// Bench for cdb_request_buffer (DEPTH=4, WAIT_W=8).
// Each table row gives the inputs for one cycle and the outputs expected in
// that same cycle, i.e. before the rising edge that consumes the inputs.
// Hand-written sequences cover head-wait saturation and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_cdb_request_buffer;
  import rv32i_types::*;

  logic         clk = 1'b0;
  logic         rst;
  cdb_entry_t   fu_result;
  logic         fu_result_valid;
  logic         fu_ready;
  logic         flush;
  cdb_entry_t   complete;
  logic         complete_valid;
  logic         cdb_grant;
  logic [2:0]   count;
  logic [7:0]   head_wait;

  cdb_request_buffer #(.DEPTH(4), .WAIT_W(8), .SIM_CHECKS(1'b0)) dut (
    .clk(clk), .rst(rst),
    .fu_result(fu_result), .fu_result_valid(fu_result_valid), .fu_ready(fu_ready),
    .flush(flush),
    .complete(complete), .complete_valid(complete_valid), .cdb_grant(cdb_grant),
    .count(count), .head_wait(head_wait)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       flush;
    logic       valid;
    cdb_entry_t res;
    logic       grant;
    logic       e_valid;
    cdb_entry_t e_comp;
    int         e_count;
    logic       e_ready;
    int         e_hw;
  } vec_t;

  vec_t tbl[$];
  int   n_applied = 0;
  int   n_miscmp  = 0;

  function automatic cdb_entry_t ent(int t, int d);
    cdb_entry_t e;
    e.tag  = 6'(t);
    e.data = 32'(d);
    return e;
  endfunction

  // f v tag data g | ev etag edata cnt rdy hw
  task automatic add(input logic f, input logic v, input int t, input int d, input logic g,
                     input logic ev, input int et, input int ed, input int cnt,
                     input logic rdy, input int hw);
    vec_t x;
    x.flush = f; x.valid = v; x.res = ent(t, d); x.grant = g;
    x.e_valid = ev; x.e_comp = ev ? ent(et, ed) : '0;
    x.e_count = cnt; x.e_ready = rdy; x.e_hw = hw;
    tbl.push_back(x);
  endtask

  task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; fu_result_valid = 1'b0; fu_result = '0; cdb_grant = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // Single result: push A, grant two cycles later.
    add(0,1, 3,'h11,0, 0,0,0,     0,1,0);
    add(0,0, 0,0,   0, 1,3,'h11,  1,1,0);
    add(0,0, 0,0,   1, 1,3,'h11,  1,1,1);
    add(0,0, 0,0,   0, 0,0,0,     0,1,0);
    // Fill, backpressure: E dropped, then drain A..D in order.
    add(0,1, 1,'hA1,0, 0,0,0,     0,1,0);
    add(0,1, 2,'hB2,0, 1,1,'hA1,  1,1,0);
    add(0,1, 4,'hC3,0, 1,1,'hA1,  2,1,1);
    add(0,1, 5,'hD4,0, 1,1,'hA1,  3,1,2);
    add(0,1, 6,'hE5,0, 1,1,'hA1,  4,0,3);
    add(0,0, 0,0,   1, 1,1,'hA1,  4,0,4);
    add(0,0, 0,0,   1, 1,2,'hB2,  3,1,0);
    add(0,0, 0,0,   1, 1,4,'hC3,  2,1,0);
    add(0,0, 0,0,   1, 1,5,'hD4,  1,1,0);
    add(0,0, 0,0,   0, 0,0,0,     0,1,0);
    // Concurrent push/pop at count 2.
    add(0,1, 7,'h71,0, 0,0,0,     0,1,0);
    add(0,1, 8,'h82,0, 1,7,'h71,  1,1,0);
    add(0,1, 9,'h93,1, 1,7,'h71,  2,1,1);
    add(0,0, 0,0,   0, 1,8,'h82,  2,1,0);
    add(0,0, 0,0,   1, 1,8,'h82,  2,1,1);
    add(0,0, 0,0,   1, 1,9,'h93,  1,1,0);
    add(0,0, 0,0,   0, 0,0,0,     0,1,0);
    // Full with grant and push: F dropped, count 3 afterwards.
    add(0,1,10,'hA0,0, 0,0,0,     0,1,0);
    add(0,1,11,'hA1,0, 1,10,'hA0, 1,1,0);
    add(0,1,12,'hA2,0, 1,10,'hA0, 2,1,1);
    add(0,1,13,'hA3,0, 1,10,'hA0, 3,1,2);
    add(0,1,14,'hFF,1, 1,10,'hA0, 4,0,3);
    add(0,0, 0,0,   0, 1,11,'hA1, 3,1,0);
    add(0,0, 0,0,   1, 1,11,'hA1, 3,1,1);
    add(0,0, 0,0,   1, 1,12,'hA2, 2,1,0);
    add(0,0, 0,0,   1, 1,13,'hA3, 1,1,0);
    add(0,0, 0,0,   0, 0,0,0,     0,1,0);
    // Flush beats push and grant at count 3.
    add(0,1,15,'h01,0, 0,0,0,     0,1,0);
    add(0,1,16,'h02,0, 1,15,'h01, 1,1,0);
    add(0,1,17,'h03,0, 1,15,'h01, 2,1,1);
    add(1,1,18,'h04,1, 1,15,'h01, 3,1,2);
    add(0,0, 0,0,   0, 0,0,0,     0,1,0);
    add(0,1,19,'h05,0, 0,0,0,     0,1,0);
    add(0,0, 0,0,   1, 1,19,'h05, 1,1,0);
    // Grant while empty is ignored.
    add(0,0, 0,0,   1, 0,0,0,     0,1,0);
    add(0,0, 0,0,   0, 0,0,0,     0,1,0);

    step(); step();
    rst = 1'b0;

    foreach (tbl[i]) begin
      flush = tbl[i].flush; fu_result_valid = tbl[i].valid;
      fu_result = tbl[i].res; cdb_grant = tbl[i].grant;
      #1;
      chk("complete_valid", i, 64'(complete_valid), 64'(tbl[i].e_valid));
      chk("complete",       i, 64'(complete),       64'(tbl[i].e_comp));
      chk("count",          i, 64'(count),          64'(tbl[i].e_count));
      chk("fu_ready",       i, 64'(fu_ready),       64'(tbl[i].e_ready));
      chk("head_wait",      i, 64'(head_wait),      64'(tbl[i].e_hw));
      step();
    end

    // Saturation: one entry held ungranted for 300 cycles.
    idle_inputs();
    fu_result_valid = 1'b1; fu_result = ent(20, 'h55);
    step();
    idle_inputs();
    for (int i = 0; i < 300; i++) begin
      #1;
      if (i == 0 || i == 1 || i == 254 || i == 255 || i == 256 || i == 299) begin
        chk("sat_head_wait", 1000 + i, 64'(head_wait), 64'((i > 255) ? 255 : i));
        chk("sat_count",     1000 + i, 64'(count),     64'd1);
      end
      step();
    end

    // Reset mid-operation, with a competing push and grant.
    rst = 1'b1; fu_result_valid = 1'b1; fu_result = ent(21, 'h66); cdb_grant = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("rst_count",          2000, 64'(count),          64'd0);
    chk("rst_fu_ready",       2000, 64'(fu_ready),       64'd1);
    chk("rst_complete_valid", 2000, 64'(complete_valid), 64'd0);
    chk("rst_complete",       2000, 64'(complete),       64'd0);
    chk("rst_head_wait",      2000, 64'(head_wait),      64'd0);
    step();
    chk("rst_hold_count",     2001, 64'(count),          64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscmp);
    $finish;
  end

endmodule
